// File: rtl/mem_lsu.sv
// Load/store unit bridging a valid/ready request port to a 128-word data memory.
// Define MEM_LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module mem_lsu (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        dm_we,
   output logic [6:0]  dm_addr,
   output logic [31:0] dm_din,
   output logic [1:0]  dm_memop,
   input  logic [31:0] dm_dout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RMW_RD,
      S_WR,
      S_RESP
   } state_e;

   state_e      state_q, state_d;
   logic        we_q;
   logic [8:0]  addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic        accept;
   logic        is_word;
   logic        is_half;
   logic        range_err;
   logic        mis_err;
   logic        req_err;
   logic [8:0]  addr_al;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] ld_data;
   logic [31:0] merged;

   assign is_word   = req_size[1];
   assign is_half   = (req_size == 2'b01);
   assign range_err = |req_addr[31:9];
   assign mis_err   = (is_half & req_addr[0])
                    | (is_word & |req_addr[1:0]);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
   assign req_err = range_err | mis_err;
   assign addr_al = req_addr[8:0];
`else
   // Misaligned accesses silently drop the low bits below the access size.
   assign req_err = range_err;
   assign addr_al = {req_addr[8:2],
                     req_addr[1] & ~is_word,
                     req_addr[0] & ~is_word & ~is_half};
`endif

   assign req_ready = rstn & (state_q == S_IDLE);
   assign accept    = req_valid & req_ready;

   always_comb begin
      lane_b = dm_dout[7:0];
      unique case (addr_q[1:0])
         2'b00: lane_b = dm_dout[7:0];
         2'b01: lane_b = dm_dout[15:8];
         2'b10: lane_b = dm_dout[23:16];
         2'b11: lane_b = dm_dout[31:24];
      endcase
   end

   assign lane_h = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];

   always_comb begin
      ld_data = dm_dout;
      unique case (size_q)
         2'b00:   ld_data = {{24{~uns_q & lane_b[7]}}, lane_b};
         2'b01:   ld_data = {{16{~uns_q & lane_h[15]}}, lane_h};
         default: ld_data = dm_dout;
      endcase
   end

   always_comb begin
      merged = dm_dout;
      if (size_q == 2'b00) begin
         unique case (addr_q[1:0])
            2'b00: merged[7:0]   = wdata_q[7:0];
            2'b01: merged[15:8]  = wdata_q[7:0];
            2'b10: merged[23:16] = wdata_q[7:0];
            2'b11: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merged[31:16] = wdata_q[15:0];
      end else begin
         merged[15:0] = wdata_q[15:0];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (req_err)
                  state_d = S_RESP;
               else if (!req_we)
                  state_d = S_RD;
               else if (is_word)
                  state_d = S_WR;
               else
                  state_d = S_RMW_RD;
            end
         end
         S_RD:     state_d = S_RESP;
         S_RMW_RD: state_d = S_WR;
         S_WR:     state_d = S_RESP;
         S_RESP:   if (resp_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= addr_al;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            err_q   <= req_err;
            rdata_q <= '0;
         end
         if (state_q == S_RD)
            rdata_q <= ld_data;
         // The merged word replaces the store data so WR drives one register.
         if (state_q == S_RMW_RD)
            wdata_q <= merged;
      end
   end

   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign dm_we      = (state_q == S_WR) & we_q;
   assign dm_din     = (state_q == S_WR) ? wdata_q : 32'h0;
   assign dm_addr    = (state_q == S_IDLE) ? 7'h0 : addr_q[8:2];
   assign dm_memop   = 2'b00;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a behavioural 128-word memory.
// Expectations follow MEM_LSU_MISALIGN_TRAP_EN when it is defined.
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        dm_we;
   logic [6:0]  dm_addr;
   logic [31:0] dm_din;
   logic [1:0]  dm_memop;
   logic [31:0] dm_dout;

   logic [31:0] mem [0:127];
   logic        pl_we = 1'b0;
   logic [6:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;
   int          we_total = 0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_lsu dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_size    (req_size),
      .req_unsigned(req_unsigned),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .dm_we       (dm_we),
      .dm_addr     (dm_addr),
      .dm_din      (dm_din),
      .dm_memop    (dm_memop),
      .dm_dout     (dm_dout)
   );

   assign dm_dout = mem[dm_addr];

   always @(posedge clk) begin
      if (dm_we) begin
         mem[dm_addr] <= dm_din;
         we_total <= we_total + 1;
      end else if (pl_we) begin
         mem[pl_addr] <= pl_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [6:0] a, input logic [31:0] d);
      pl_addr = a;
      pl_data = d;
      pl_we   = 1'b1;
      @(posedge clk);
      #1;
      pl_we   = 1'b0;
   endtask

   task automatic do_req(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz,
                         input logic u, output int lat, output int wcnt,
                         output int wcyc, output logic [31:0] waddr,
                         output logic [31:0] wdin);
      lat   = 0;
      wcnt  = 0;
      wcyc  = 0;
      waddr = '0;
      wdin  = '0;
      req_we       = we;
      req_addr     = a;
      req_wdata    = wd;
      req_size     = sz;
      req_unsigned = u;
      req_valid    = 1'b1;
      chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (dm_we) begin
            wcnt++;
            wcyc  = k;
            waddr = {25'b0, dm_addr};
            wdin  = dm_din;
         end
         if (resp_valid) begin
            lat = k;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic resp_done();
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      chk("resp_valid_drop", {31'b0, resp_valid}, 32'd0);
      chk("req_ready_back", {31'b0, req_ready}, 32'd1);
   endtask

   int          lat, wcnt, wcyc, we_snap;
   logic [31:0] waddr, wdin, rsnap;

   initial begin
      #3;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst_dm_we", {31'b0, dm_we}, 32'd0);
      chk("rst_dm_addr", {25'b0, dm_addr}, 32'h0);
      chk("rst_dm_din", dm_din, 32'h0);
      chk("rst_dm_memop", {30'b0, dm_memop}, 32'h0);
      #9;
      rstn = 1'b1;
      #1;
      chk("rel_req_ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1;

      // sb 0xAB -> 0x13 over 0x11223344
      preload(7'd4, 32'h11223344);
      do_req(1'b1, 32'h13, 32'h000000AB, 2'b00, 1'b0,
             lat, wcnt, wcyc, waddr, wdin);
      chk("sb_lat", 32'(lat), 32'd3);
      chk("sb_wcnt", 32'(wcnt), 32'd1);
      chk("sb_wcyc", 32'(wcyc), 32'd2);
      chk("sb_waddr", waddr, 32'd4);
      chk("sb_wdin", wdin, 32'hAB223344);
      chk("sb_err", {31'b0, resp_err}, 32'd0);
      chk("sb_rdata", resp_rdata, 32'h0);
      chk("sb_mem", mem[4], 32'hAB223344);
      resp_done();

      // loads from word 0x11803344
      preload(7'd4, 32'h11803344);
      do_req(1'b0, 32'h12, 32'h0, 2'b00, 1'b0,
             lat, wcnt, wcyc, waddr, wdin);
      chk("lb_lat", 32'(lat), 32'd2);
      chk("lb_wcnt", 32'(wcnt), 32'd0);
      chk("lb_rdata", resp_rdata, 32'hFFFFFF80);
      resp_done();
      do_req(1'b0, 32'h12, 32'h0, 2'b00, 1'b1,
             lat, wcnt, wcyc, waddr, wdin);
      chk("lbu_rdata", resp_rdata, 32'h00000080);
      resp_done();
      do_req(1'b0, 32'h12, 32'h0, 2'b01, 1'b1,
             lat, wcnt, wcyc, waddr, wdin);
      chk("lhu_rdata", resp_rdata, 32'h00001180);
      resp_done();
      do_req(1'b0, 32'h10, 32'h0, 2'b00, 1'b0,
             lat, wcnt, wcyc, waddr, wdin);
      chk("lb0_rdata", resp_rdata, 32'h00000044);
      resp_done();
      do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0,
             lat, wcnt, wcyc, waddr, wdin);
      chk("lw_rdata", resp_rdata, 32'h11803344);
      resp_done();

      // sw 0xDEADBEEF -> 0x20
      do_req(1'b1, 32'h20, 32'hDEADBEEF, 2'b10, 1'b0,
             lat, wcnt, wcyc, waddr, wdin);
      chk("sw_lat", 32'(lat), 32'd2);
      chk("sw_wcnt", 32'(wcnt), 32'd1);
      chk("sw_wcyc", 32'(wcyc), 32'd1);
      chk("sw_waddr", waddr, 32'd8);
      chk("sw_wdin", wdin, 32'hDEADBEEF);
      chk("sw_err", {31'b0, resp_err}, 32'd0);
      chk("sw_mem", mem[8], 32'hDEADBEEF);
      resp_done();

      // sh 0xBEEF -> 0x16 over 0x8765CAFE
      preload(7'd5, 32'h8765CAFE);
      do_req(1'b1, 32'h16, 32'h0000BEEF, 2'b01, 1'b0,
             lat, wcnt, wcyc, waddr, wdin);
      chk("sh_lat", 32'(lat), 32'd3);
      chk("sh_wdin", wdin, 32'hBEEFCAFE);
      resp_done();

      // lh from 0x15 (misaligned)
      preload(7'd5, 32'h8765CAFE);
      we_snap = we_total;
      do_req(1'b0, 32'h15, 32'h0, 2'b01, 1'b0,
             lat, wcnt, wcyc, waddr, wdin);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
      chk("lh_mis_lat", 32'(lat), 32'd1);
      chk("lh_mis_err", {31'b0, resp_err}, 32'd1);
      chk("lh_mis_rdata", resp_rdata, 32'h0);
`else
      chk("lh_mis_lat", 32'(lat), 32'd2);
      chk("lh_mis_err", {31'b0, resp_err}, 32'd0);
      chk("lh_mis_rdata", resp_rdata, 32'hFFFFCAFE);
`endif
      chk("lh_mis_nowe", 32'(we_total - we_snap), 32'd0);
      resp_done();

      // sw to 0x200: range error, response held 5 cycles
      we_snap = we_total;
      do_req(1'b1, 32'h200, 32'h12345678, 2'b10, 1'b0,
             lat, wcnt, wcyc, waddr, wdin);
      chk("oor_lat", 32'(lat), 32'd1);
      chk("oor_err", {31'b0, resp_err}, 32'd1);
      rsnap = resp_rdata;
      chk("oor_rdata", rsnap, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", {31'b0, resp_valid}, 32'd1);
         chk("hold_err", {31'b0, resp_err}, 32'd1);
         chk("hold_rdata", resp_rdata, 32'h0);
         chk("hold_ready", {31'b0, req_ready}, 32'd0);
      end
      chk("oor_nowe", 32'(we_total - we_snap), 32'd0);
      resp_done();

      // reset while in RMW_RD
      preload(7'd6, 32'h55667788);
      we_snap = we_total;
      req_we       = 1'b1;
      req_addr     = 32'h18;
      req_wdata    = 32'h00000099;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_valid    = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("rmw_addr", {25'b0, dm_addr}, 32'd6);
      #2;
      rstn = 1'b0;
      #1;
      chk("rmw_rst_we", {31'b0, dm_we}, 32'd0);
      chk("rmw_rst_ready", {31'b0, req_ready}, 32'd0);
      chk("rmw_rst_addr", {25'b0, dm_addr}, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      #1;
      chk("rmw_rel_ready", {31'b0, req_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("rmw_nowe", 32'(we_total - we_snap), 32'd0);
      chk("rmw_mem", mem[6], 32'h55667788);
      chk("rmw_idle_valid", {31'b0, resp_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
